// File: rtl/addsub_pipe.sv
// Pipelined two's-complement adder/subtractor: one BLOCK-bit slice per stage, carry registered between stages.
// Define ADDSUB_SAT_EN to clamp the result on signed overflow instead of wrapping.
module addsub_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int STAGES = WIDTH / BLOCK;

  logic                          advance;
  logic [STAGES-1:0]             v_q, c_q;
  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, r_q;
  logic                          m_q;

  logic [STAGES-1:0]             v_src, c_src;
  logic [STAGES-1:0][WIDTH-1:0]  a_src, b_src, r_src, r_nxt;
  logic [STAGES-1:0][BLOCK:0]    sum;
  logic                          m_nxt;

  logic [WIDTH-1:0]              fin_res;
  logic                          fin_c, fin_ovf;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Stage 0 takes the live operands; B is inverted up front so later stages only add.
  always_comb begin
    v_src = '0;
    c_src = '0;
    a_src = '0;
    b_src = '0;
    r_src = '0;
    r_nxt = '0;
    sum   = '0;
    v_src[0] = in_valid;
    c_src[0] = sub;
    a_src[0] = a;
    b_src[0] = sub ? ~b : b;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      r_src[k] = r_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      sum[k] = {1'b0, a_src[k][k*BLOCK +: BLOCK]} + {1'b0, b_src[k][k*BLOCK +: BLOCK]}
             + (BLOCK+1)'(c_src[k]);
      r_nxt[k] = r_src[k];
      r_nxt[k][k*BLOCK +: BLOCK] = sum[k][BLOCK-1:0];
    end
    // Carry into the MSB recovered from the MSB sum bit and its operand bits.
    m_nxt = sum[STAGES-1][BLOCK-1] ^ a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1];
  end

  always_comb begin
    fin_c   = c_q[STAGES-1];
    fin_ovf = fin_c ^ m_q;
    fin_res = r_q[STAGES-1];
`ifdef ADDSUB_SAT_EN
    // A wrapped negative sign means the true result was positive, and vice versa.
    if (fin_ovf)
      fin_res = r_q[STAGES-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v_q       <= '0;
      c_q       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      m_q       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        v_q[k] <= v_src[k];
        c_q[k] <= sum[k][BLOCK];
        a_q[k] <= a_src[k];
        b_q[k] <= b_src[k];
        r_q[k] <= r_nxt[k];
      end
      m_q       <= m_nxt;
      out_valid <= v_q[STAGES-1];
      result    <= fin_res;
      carry_out <= fin_c;
      overflow  <= fin_ovf;
      zero      <= (fin_res == '0);
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed self-checking bench for addsub_pipe (default 32-bit, 8-bit slices).
// Expected results follow ADDSUB_SAT_EN when the bench is built with it.
module tb_addsub_pipe;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] result;
  logic        carry_out, overflow, zero;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  addsub_pipe #(.WIDTH(32), .BLOCK(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

`ifdef ADDSUB_SAT_EN
  localparam logic [31:0] R_OVF_ADD = 32'h7FFF_FFFF;
  localparam logic [31:0] R_OVF_SUB = 32'h8000_0000;
`else
  localparam logic [31:0] R_OVF_ADD = 32'h8000_0000;
  localparam logic [31:0] R_OVF_SUB = 32'h7FFF_FFFF;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] r;
    logic        c;
    logic        o;
    logic        z;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] op_a [6];
  logic [31:0] op_b [6];
  logic        op_s [6];
  logic [31:0] exp6 [6];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    @(posedge clock); #1;
    a = v.a; b = v.b; sub = v.s; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 4);
    chk({tag, "_res"}, result, v.r);
    chk({tag, "_c"}, {31'b0, carry_out}, {31'b0, v.c});
    chk({tag, "_ovf"}, {31'b0, overflow}, {31'b0, v.o});
    chk({tag, "_zero"}, {31'b0, zero}, {31'b0, v.z});
  endtask

  logic        first, acc;
  int          stall, cnt, cyc, guard, seen, lat;
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{32'h0000_0000, 32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, R_OVF_ADD,     1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, R_OVF_SUB,     1'b1, 1'b1, 1'b0};
    vecs[5] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    op_a = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60};
    op_b = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4, 32'h5};
    op_s = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    exp6 = '{32'h10, 32'h1F, 32'h32, 32'h3D, 32'h54, 32'h5B};

    // reset state
    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_carry", {31'b0, carry_out}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clock); reset = 1'b0;

    run_vec(vecs[0], "add");
    run_vec(vecs[1], "sub_zero");
    run_vec(vecs[2], "sub_borrow");
    run_vec(vecs[3], "ovf_add");
    run_vec(vecs[4], "ovf_sub");
    run_vec(vecs[5], "ripple");
    run_vec(vecs[6], "wrap_zero");

    // back-to-back issue with a 3-cycle output stall
    @(posedge clock); #1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          a = op_a[i]; b = op_b[i]; sub = op_s[i]; in_valid = 1'b1;
          guard = 0;
          do begin
            @(negedge clock); #1;
            acc = in_ready;
            @(posedge clock); #1;
            guard++;
          end while (!acc && guard < 50);
        end
        in_valid = 1'b0;
      end
      begin
        first = 1'b1; stall = 0; cnt = 0; cyc = 0;
        while (cnt < 6 && cyc < 100) begin
          @(negedge clock);
          cyc++;
          if (out_valid && first) begin
            first = 1'b0; out_ready = 1'b0; held = result; stall = 3;
          end else if (stall > 0) begin
            chk("bp_stall_ready", {31'b0, in_ready}, 32'd0);
            chk("bp_stall_hold", result, held);
            stall--;
            if (stall == 0) out_ready = 1'b1;
          end
          if (out_valid && out_ready) begin
            chk($sformatf("bp_res%0d", cnt), result, exp6[cnt]);
            cnt++;
          end
        end
        chk("bp_count", cnt, 6);
        @(negedge clock);
        chk("bp_drain", {31'b0, out_valid}, 32'd0);
      end
    join

    // asynchronous reset clears a held result before any clock edge
    out_ready = 1'b0;
    @(posedge clock); #1;
    a = 32'h5; b = 32'h3; sub = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
    chk("async_pre_valid", {31'b0, out_valid}, 32'd1);
    @(negedge clock); reset = 1'b1;
    #1;
    chk("async_valid", {31'b0, out_valid}, 32'd0);
    chk("async_result", result, 32'd0);
    out_ready = 1'b1;
    @(negedge clock); reset = 1'b0;

    // reset with three operations in flight
    @(posedge clock); #1;
    for (int i = 0; i < 3; i++) begin
      a = vecs[i].a; b = vecs[i].b; sub = vecs[i].s; in_valid = 1'b1;
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    chk("midrst_stale", seen, 0);
    run_vec(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
